// File: rtl/otp_pmem_emu.sv
// Byte-wide OTP program-memory responder for the PMEM bus: serves read cycles and
// applies one-way (0->1) programming with pulse-width and VDDP checks.
module otp_pmem_emu #(
  parameter int unsigned AW     = 13,
  parameter int unsigned RD_LAT = 2,
  parameter int unsigned TPGM   = 16,
  parameter int unsigned TREC   = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        pmem_clk,
  input  logic        csb,
  input  logic        re,
  input  logic        pgm,
  input  logic [1:0]  twlb,
  input  logic        vddp,
  input  logic [15:0] a,
  input  logic [7:0]  pswdat,
  output logic [7:0]  q,
  output logic        busy,
  output logic        pgm_err
);

  localparam int unsigned DEPTH = 1 << AW;
  localparam int unsigned CW    = 16;

  typedef enum logic [1:0] {S_IDLE, S_RD, S_PGM, S_REC} state_t;

  state_t          r_state, w_state_nxt;
  logic            r_sync1, r_sync2, r_sync_d;
  logic [AW-1:0]   r_addr, w_addr_nxt;
  logic            r_oor, w_oor_nxt;
  logic [7:0]      r_data, w_data_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic [CW-1:0]   r_lat, w_lat_nxt;
  logic [7:0]      r_q, w_q_nxt;
  logic            r_busy, w_busy_nxt;
  logic            r_err, w_err_nxt;
  logic            w_rise, w_oor, w_commit;
  logic [7:0]      w_rd_data;

  // Array comes up zeroed at configuration and is deliberately untouched by reset.
  logic [7:0] r_mem [DEPTH] = '{default: 8'h00};

  assign w_rise    = r_sync2 & ~r_sync_d;
  assign w_oor     = (a >> AW) != 16'd0;
  assign w_rd_data = r_mem[r_addr];

  assign q       = r_q;
  assign busy    = r_busy;
  assign pgm_err = r_err;

  // pmem_clk synchroniser and edge register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_sync_d <= 1'b0;
    end else begin
      r_sync1  <= pmem_clk;
      r_sync2  <= r_sync1;
      r_sync_d <= r_sync2;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_oor   <= 1'b0;
      r_data  <= 8'h00;
      r_cnt   <= '0;
      r_lat   <= '0;
      r_q     <= 8'h00;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_addr  <= w_addr_nxt;
      r_oor   <= w_oor_nxt;
      r_data  <= w_data_nxt;
      r_cnt   <= w_cnt_nxt;
      r_lat   <= w_lat_nxt;
      r_q     <= w_q_nxt;
      r_busy  <= w_busy_nxt;
      r_err   <= w_err_nxt;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_commit) r_mem[r_addr] <= r_mem[r_addr] | r_data;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_oor_nxt   = r_oor;
    w_data_nxt  = r_data;
    w_cnt_nxt   = r_cnt;
    w_lat_nxt   = r_lat;
    w_q_nxt     = r_q;
    w_busy_nxt  = r_busy;
    w_err_nxt   = r_err;
    w_commit    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_rise && !csb) begin
          if (re && !pgm) begin
            w_addr_nxt  = a[AW-1:0];
            w_oor_nxt   = w_oor;
            w_lat_nxt   = CW'(RD_LAT) + CW'(twlb != 2'b00);
            w_cnt_nxt   = CW'(1);
            w_busy_nxt  = 1'b1;
            w_state_nxt = S_RD;
          end else if (pgm && !re) begin
            if (!vddp) begin
              w_err_nxt = 1'b1;
            end else if (w_oor) begin
              // Unreachable address behaves like an aborted pulse.
              w_err_nxt   = 1'b1;
              w_cnt_nxt   = CW'(1);
              w_busy_nxt  = 1'b1;
              w_state_nxt = S_REC;
            end else begin
              w_addr_nxt  = a[AW-1:0];
              w_data_nxt  = pswdat;
              w_cnt_nxt   = '0;
              w_busy_nxt  = 1'b1;
              w_state_nxt = S_PGM;
            end
          end
        end
      end
      S_RD: begin
        if (r_cnt == r_lat) w_q_nxt = r_oor ? 8'hFF : w_rd_data;
        if (r_cnt > r_lat) begin
          w_busy_nxt  = 1'b0;
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      S_PGM: begin
        if (r_sync2 && !csb) begin
          if (r_cnt + CW'(1) == CW'(TPGM)) begin
            w_commit    = 1'b1;
            w_err_nxt   = 1'b0;
            w_cnt_nxt   = CW'(1);
            w_state_nxt = S_REC;
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end else begin
          w_err_nxt   = 1'b1;
          w_cnt_nxt   = CW'(1);
          w_state_nxt = S_REC;
        end
      end
      S_REC: begin
        if (r_cnt >= CW'(TREC)) begin
          w_busy_nxt  = 1'b0;
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_otp_pmem_emu.sv
// Bench for otp_pmem_emu: directed pins plus random transactions against a
// transaction-level model of the OTP array, q and pgm_err.
module tb_otp_pmem_emu;

  localparam int AW = 13, RD_LAT = 2, TPGM = 16, TREC = 4;

  logic        i_clk = 1'b0;
  logic        i_rst, pmem_clk, csb, re, pgm, vddp;
  logic [1:0]  twlb;
  logic [15:0] a;
  logic [7:0]  pswdat, q;
  logic        busy, pgm_err;

  otp_pmem_emu #(.AW(AW), .RD_LAT(RD_LAT), .TPGM(TPGM), .TREC(TREC)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .pmem_clk(pmem_clk), .csb(csb), .re(re), .pgm(pgm),
    .twlb(twlb), .vddp(vddp), .a(a), .pswdat(pswdat), .q(q), .busy(busy), .pgm_err(pgm_err)
  );

  always #5 i_clk = ~i_clk;

  int         n_tests = 0, n_fail = 0;
  bit         chk_en = 1'b0;
  logic [7:0] mem_m [0:(1<<AW)-1];
  logic [7:0] exp_q;
  logic       exp_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Whenever no transaction is in flight, outputs must match the model.
  always @(negedge i_clk) begin
    if (chk_en && !i_rst) begin
      chk("idle_q", 32'(q), 32'(exp_q));
      chk("idle_err", 32'(pgm_err), 32'(exp_err));
      chk("idle_busy", 32'(busy), 32'd0);
    end
  end

  // One pmem_clk pulse of p i_clk cycles; reports busy cycles and the last two q seen while busy.
  task automatic run_pulse(input int p, output int bc, output logic [7:0] q_last, output logic [7:0] q_prev);
    int t;
    bc = 0; q_last = q; q_prev = q;
    pmem_clk = 1'b1;
    for (t = 1; t < 400; t++) begin
      @(negedge i_clk);
      if (t == p) pmem_clk = 1'b0;
      if (busy) begin
        bc++;
        q_prev = q_last;
        q_last = q;
      end else if (t >= p + 8) begin
        break;
      end
    end
    if (t >= 400) begin
      n_tests++; n_fail++;
      $display("FAIL txn_timeout: busy still %0b after %0d cycles, expected idle", busy, t);
    end
  endtask

  function automatic logic [7:0] model_read(input logic [15:0] addr);
    if (addr >= 16'(1 << AW)) return 8'hFF;
    return mem_m[addr[AW-1:0]];
  endfunction

  task automatic do_read(input logic [15:0] addr, input logic [1:0] tw, input int p, output logic [7:0] got);
    int bc, lat; logic [7:0] ql, qp, ev;
    chk_en = 1'b0;
    @(negedge i_clk);
    csb = 1'b0; re = 1'b1; pgm = 1'b0; a = addr; twlb = tw;
    pswdat = 8'($urandom); vddp = 1'($urandom);
    run_pulse(p, bc, ql, qp);
    lat = RD_LAT + ((tw != 2'b00) ? 1 : 0);
    ev  = model_read(addr);
    chk("rd_busy_cycles", 32'(bc), 32'(lat + 1));
    chk("rd_q_before_update", 32'(qp), 32'(exp_q));
    chk("rd_q", 32'(ql), 32'(ev));
    exp_q = ev; got = ql;
    chk_en = 1'b1;
  endtask

  task automatic do_prog(input logic [15:0] addr, input logic [7:0] d, input int p, input logic vd);
    int bc; logic [7:0] ql, qp;
    chk_en = 1'b0;
    @(negedge i_clk);
    csb = 1'b0; re = 1'b0; pgm = 1'b1; a = addr; pswdat = d; vddp = vd; twlb = 2'($urandom);
    run_pulse(p, bc, ql, qp);
    if (!vd) begin
      exp_err = 1'b1;
      chk("pg_novddp_busy", 32'(bc), 32'd0);
    end else if (addr >= 16'(1 << AW)) begin
      exp_err = 1'b1;
    end else if (p > TPGM) begin
      mem_m[addr[AW-1:0]] = mem_m[addr[AW-1:0]] | d;
      exp_err = 1'b0;
      chk("pg_ok_busy", 32'(bc), 32'(TPGM + TREC));
    end else begin
      exp_err = 1'b1;
      chk("pg_abort_busy", 32'(bc), 32'(p + TREC));
    end
    chk("pg_err", 32'(pgm_err), 32'(exp_err));
    chk_en = 1'b1;
  endtask

  task automatic do_ignored(input int p);
    int bc; logic [7:0] ql, qp;
    chk_en = 1'b0;
    @(negedge i_clk);
    if ($urandom_range(0, 1) == 0) begin
      csb = 1'b1; re = 1'($urandom); pgm = 1'($urandom);
    end else begin
      csb = 1'b0; re = 1'($urandom); pgm = re;
    end
    a = 16'h0010; pswdat = 8'hFF; vddp = 1'b1;
    run_pulse(p, bc, ql, qp);
    chk("ignored_busy", 32'(bc), 32'd0);
    chk_en = 1'b1;
  endtask

  function automatic logic [15:0] rand_addr();
    case ($urandom_range(0, 5))
      0: return 16'h0010;
      1: return 16'h0020;
      2: return 16'h1FFF;
      3: return 16'((1 << AW) + $urandom_range(0, 100));
      4: return {3'b000, 13'($urandom)};
      default: return 16'h0050;
    endcase
  endfunction

  initial begin
    logic [7:0] got;
    int bc;
    for (int i = 0; i < (1 << AW); i++) mem_m[i] = 8'h00;
    exp_q = 8'h00; exp_err = 1'b0;
    i_rst = 1'b1; pmem_clk = 1'b0; csb = 1'b1; re = 1'b0; pgm = 1'b0;
    vddp = 1'b1; twlb = 2'b00; a = 16'h0000; pswdat = 8'h00;
    repeat (3) @(negedge i_clk);
    chk("rst_q", 32'(q), 32'h00);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(pgm_err), 32'd0);
    i_rst = 1'b0;
    repeat (3) @(negedge i_clk);
    chk_en = 1'b1;

    do_read(16'h0010, 2'b00, 3, got);   chk("first_read", 32'(got), 32'h00);
    do_prog(16'h0010, 8'hA5, 20, 1'b1);
    do_read(16'h0010, 2'b00, 3, got);   chk("prog_a5", 32'(got), 32'hA5);
    chk("prog_a5_err", 32'(pgm_err), 32'd0);
    do_prog(16'h0010, 8'h0F, 20, 1'b1);
    do_read(16'h0010, 2'b00, 3, got);   chk("or_0f", 32'(got), 32'hAF);
    do_prog(16'h0010, 8'h00, 20, 1'b1);
    do_read(16'h0010, 2'b00, 3, got);   chk("or_00", 32'(got), 32'hAF);
    do_prog(16'h0020, 8'hFF, 5, 1'b1);
    chk("short_err", 32'(pgm_err), 32'd1);
    do_read(16'h0020, 2'b00, 3, got);   chk("short_nowrite", 32'(got), 32'h00);
    do_prog(16'h0020, 8'h01, 20, 1'b1);
    chk("good_clears_err", 32'(pgm_err), 32'd0);
    do_prog(16'h0060, 8'hFF, 20, 1'b0);
    chk("novddp_err", 32'(pgm_err), 32'd1);
    do_read(16'h0010, 2'b01, 3, got);   chk("twlb_read", 32'(got), 32'hAF);
    do_read(16'h2000, 2'b00, 3, got);   chk("oor_read", 32'(got), 32'hFF);

    // Second rise lands in recovery after a commit and must be dropped.
    chk_en = 1'b0;
    @(negedge i_clk);
    csb = 1'b0; re = 1'b0; pgm = 1'b1; a = 16'h0050; pswdat = 8'h3C; vddp = 1'b1;
    pmem_clk = 1'b1; bc = 0;
    for (int t = 1; t < 45; t++) begin
      @(negedge i_clk);
      if (t == 17) pmem_clk = 1'b0;
      if (t == 18) begin pmem_clk = 1'b1; a = 16'h0030; pswdat = 8'hFF; end
      if (t == 30) pmem_clk = 1'b0;
      if (busy) bc++;
    end
    chk("drop_busy_cycles", 32'(bc), 32'(TPGM + TREC));
    mem_m[16'h0050] = 8'h3C; exp_err = 1'b0;
    chk_en = 1'b1;
    do_read(16'h0030, 2'b00, 3, got);   chk("drop_nowrite", 32'(got), 32'h00);
    do_read(16'h0050, 2'b00, 3, got);   chk("drop_first_ok", 32'(got), 32'h3C);

    // Reset in the middle of a program pulse.
    do_prog(16'h0070, 8'h11, 20, 1'b0);
    chk_en = 1'b0;
    @(negedge i_clk);
    csb = 1'b0; re = 1'b0; pgm = 1'b1; a = 16'h0040; pswdat = 8'hFF; vddp = 1'b1;
    pmem_clk = 1'b1;
    repeat (10) @(negedge i_clk);
    chk("midpgm_busy", 32'(busy), 32'd1);
    i_rst = 1'b1;
    @(negedge i_clk);
    chk("midrst_q", 32'(q), 32'h00);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_err", 32'(pgm_err), 32'd0);
    pmem_clk = 1'b0;
    repeat (4) @(negedge i_clk);
    i_rst = 1'b0;
    exp_q = 8'h00; exp_err = 1'b0;
    repeat (2) @(negedge i_clk);
    chk_en = 1'b1;
    do_read(16'h0040, 2'b00, 3, got);   chk("midrst_nowrite", 32'(got), 32'h00);

    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 3))
        0: do_read(rand_addr(), 2'($urandom), $urandom_range(2, 6), got);
        1, 2: do_prog(rand_addr(), 8'($urandom), $urandom_range(1, TPGM + 6),
                      1'($urandom_range(0, 5) != 0));
        default: do_ignored($urandom_range(2, 6));
      endcase
    end

    repeat (3) @(negedge i_clk);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
